// File: rtl/preamble_sync_engine_pkg.sv
// preamble_sync_engine_pkg: shared FSM state encoding and bank-index width helper
// Contents:
//   state_t  - IDLE=0, FIND=1, DATA=2
//   bank_w() - bit width needed to index a given number of banks
package preamble_sync_engine_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIND = 2'd1,
        DATA = 2'd2
    } state_t;

    function automatic int bank_w(input int banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

endpackage

// File: rtl/preamble_sync_engine_fifo.sv
// preamble_sync_engine_fifo: sample buffer with read-pointer jump and clear
// Ports:
//   clk, rst    - clock, sync active-high reset
//   clear       - empty the buffer (read pointer catches up to write pointer)
//   push, din   - write a sample; ignored when full unless clear is also set
//   pop, dout   - advance read pointer; dout shows the head sample
//   jump        - load read pointer with jump_value (a write-pointer snapshot)
//   full, empty - occupancy flags
//   wr_ptr      - current write pointer, used by the caller for snapshots
module preamble_sync_engine_fifo #(
    parameter int DW = 1,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic          jump,
    input  logic [AW:0]   jump_value,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   wr_ptr
);

    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   rd_ptr;
    logic          wr;

    // Pointers carry one extra bit so full and empty stay distinguishable across wraps
    assign full  = (wr_ptr - rd_ptr) == {1'b1, {AW{1'b0}}};
    assign empty = wr_ptr == rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];
    assign wr    = push && (clear || !full);

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= clear ? wr_ptr : jump ? jump_value : (pop && !empty) ? rd_ptr + 1'b1 : rd_ptr;
        end
    end

endmodule

// File: rtl/preamble_sync_engine.sv
// preamble_sync_engine: finds the peak-correlation bank/sample and streams the frame from that sample
// Ports:
//   clk, rst                          - clock, sync active-high reset
//   cfg_hi_thresh / cfg_lo_thresh     - FIND entry (>=) / exit (<=) thresholds, latched on entry
//   cfg_max_frame                     - output samples per frame, 0 = unlimited, latched on entry
//   in_dat, in_vld, corr_dat          - sample stream with aligned per-bank correlations
//   all_zeros                         - silent-input flag, ends a frame when valid
//   out_dat, out_vld, out_rdy         - frame output with ready/valid backpressure
//   frequency_bank                    - winning bank, held through DATA
//   preamble_detected, find_timeout,
//   frame_end, overflow               - single-cycle event pulses
module preamble_sync_engine
    import preamble_sync_engine_pkg::*;
#(
    parameter int BANKS      = 4,
    parameter int CORR_WIDTH = 4,
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_FIND   = 64,
    localparam int BW        = bank_w(BANKS),
    localparam int FW        = $clog2(MAX_FIND + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CORR_WIDTH-1:0]       cfg_hi_thresh,
    input  logic [CORR_WIDTH-1:0]       cfg_lo_thresh,
    input  logic [15:0]                 cfg_max_frame,
    input  logic [DATA_WIDTH-1:0]       in_dat,
    input  logic                        in_vld,
    input  logic [BANKS*CORR_WIDTH-1:0] corr_dat,
    input  logic                        all_zeros,
    output logic [DATA_WIDTH-1:0]       out_dat,
    output logic                        out_vld,
    input  logic                        out_rdy,
    output logic [BW-1:0]               frequency_bank,
    output logic                        preamble_detected,
    output logic                        find_timeout,
    output logic                        frame_end,
    output logic                        overflow
);

    state_t                state, state_nxt;
    logic [CORR_WIDTH-1:0] cur_corr, peak_corr, lo_thresh;
    logic [BW-1:0]         cur_bank, peak_bank;
    logic [ADDR_WIDTH:0]   peak_ptr, wr_ptr;
    logic [15:0]           max_frame, frame_cnt;
    logic [FW-1:0]         find_cnt;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  full, empty;
    logic                  enter, lock, timeout, accept, done;
    logic                  push, pop, clear, ovf;

    // Strict '>' keeps the lowest bank index on ties
    always_comb begin
        cur_corr = corr_dat[0 +: CORR_WIDTH];
        cur_bank = '0;
        for (int i = 1; i < BANKS; i++) begin
            if (corr_dat[i*CORR_WIDTH +: CORR_WIDTH] > cur_corr) begin
                cur_corr = corr_dat[i*CORR_WIDTH +: CORR_WIDTH];
                cur_bank = BW'(i);
            end
        end
    end

    assign accept  = out_vld && out_rdy;
    assign enter   = state == IDLE && in_vld && cur_corr >= cfg_hi_thresh;
    assign lock    = state == FIND && in_vld && cur_corr <= lo_thresh;
    assign timeout = state == FIND && in_vld && !lock && find_cnt == FW'(MAX_FIND - 1);
    assign done    = state == DATA && ((in_vld && all_zeros) ||
                     (max_frame != 16'd0 && accept && frame_cnt == max_frame - 16'd1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = enter ? FIND : lock ? DATA : (timeout || done) ? IDLE : state;
    end

    // IDLE keeps clearing the buffer, so the entry sample lands in an empty buffer
    always_comb begin
        clear = state == IDLE || timeout || done;
        push  = in_vld && !timeout && !done && (enter || state != IDLE);
        pop   = state == DATA && !done && !empty && (!out_vld || out_rdy);
        ovf   = push && full && state != IDLE;
    end

    preamble_sync_engine_fifo #(
        .DW (DATA_WIDTH),
        .AW (ADDR_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .push       (push),
        .pop        (pop),
        .jump       (lock),
        .jump_value (peak_ptr),
        .din        (in_dat),
        .dout       (fifo_dout),
        .full       (full),
        .empty      (empty),
        .wr_ptr     (wr_ptr)
    );

    // Peak location is kept as the write pointer at the time the sample was pushed
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_corr <= '0;
            peak_bank <= '0;
            peak_ptr  <= '0;
            lo_thresh <= '0;
            max_frame <= '0;
            find_cnt  <= '0;
            frame_cnt <= '0;
        end else if (enter) begin
            peak_corr <= cur_corr;
            peak_bank <= cur_bank;
            peak_ptr  <= wr_ptr;
            lo_thresh <= cfg_lo_thresh;
            max_frame <= cfg_max_frame;
            find_cnt  <= FW'(1);
            frame_cnt <= '0;
        end else begin
            if (state == FIND && in_vld) find_cnt <= find_cnt + 1'b1;
            if (state == FIND && in_vld && cur_corr > peak_corr) begin
                peak_corr <= cur_corr;
                peak_bank <= cur_bank;
                peak_ptr  <= wr_ptr;
            end
            if (state == DATA && accept) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_dat           <= '0;
            out_vld           <= 1'b0;
            frequency_bank    <= '0;
            preamble_detected <= 1'b0;
            find_timeout      <= 1'b0;
            frame_end         <= 1'b0;
            overflow          <= 1'b0;
        end else begin
            out_dat           <= pop ? fifo_dout : out_dat;
            out_vld           <= done ? 1'b0 : pop ? 1'b1 : accept ? 1'b0 : out_vld;
            frequency_bank    <= lock ? peak_bank : (timeout || done) ? '0 : frequency_bank;
            preamble_detected <= lock;
            find_timeout      <= timeout;
            frame_end         <= done;
            overflow          <= ovf;
        end
    end

endmodule

// File: tb/tb_preamble_sync_engine.sv
// tb_preamble_sync_engine: directed checks of peak selection, timeout, frame limit, backpressure, overflow, reset
module tb_preamble_sync_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  hi = 4'd3, lo = 4'd2;
    logic [15:0] max_frame = 16'd0;
    logic [7:0]  in_dat = '0;
    logic        in_vld = 1'b0;
    logic [15:0] corr = '0;
    logic        all_zeros = 1'b0;
    logic        out_rdy = 1'b1;

    logic [7:0]  a_out_dat, b_out_dat;
    logic        a_out_vld, b_out_vld;
    logic [1:0]  a_bank, b_bank;
    logic        a_pre, b_pre, a_to, b_to, a_fe, b_fe, a_ovf, b_ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    preamble_sync_engine #(
        .BANKS(4), .CORR_WIDTH(4), .DATA_WIDTH(8), .ADDR_WIDTH(10), .MAX_FIND(8)
    ) dut_a (
        .clk(clk), .rst(rst), .cfg_hi_thresh(hi), .cfg_lo_thresh(lo), .cfg_max_frame(max_frame),
        .in_dat(in_dat), .in_vld(in_vld), .corr_dat(corr), .all_zeros(all_zeros),
        .out_dat(a_out_dat), .out_vld(a_out_vld), .out_rdy(out_rdy), .frequency_bank(a_bank),
        .preamble_detected(a_pre), .find_timeout(a_to), .frame_end(a_fe), .overflow(a_ovf)
    );

    preamble_sync_engine #(
        .BANKS(4), .CORR_WIDTH(4), .DATA_WIDTH(8), .ADDR_WIDTH(3), .MAX_FIND(64)
    ) dut_b (
        .clk(clk), .rst(rst), .cfg_hi_thresh(hi), .cfg_lo_thresh(lo), .cfg_max_frame(max_frame),
        .in_dat(in_dat), .in_vld(in_vld), .corr_dat(corr), .all_zeros(all_zeros),
        .out_dat(b_out_dat), .out_vld(b_out_vld), .out_rdy(out_rdy), .frequency_bank(b_bank),
        .preamble_detected(b_pre), .find_timeout(b_to), .frame_end(b_fe), .overflow(b_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [15:0] c, input logic z);
        in_dat    = d;
        corr      = c;
        all_zeros = z;
        in_vld    = 1'b1;
        tick();
        in_vld    = 1'b0;
        all_zeros = 1'b0;
    endtask

    task automatic idle();
        in_vld = 1'b0;
        tick();
    endtask

    function automatic logic [15:0] cv(input int b, input int v);
        return 16'(v) << (b * 4);
    endfunction

    initial begin
        int beats, fe, ov;
        tick();
        tick();
        chk("rst_vld", a_out_vld, 0);
        chk("rst_dat", a_out_dat, 0);
        chk("rst_bank", a_bank, 0);
        chk("rst_pre", a_pre, 0);
        rst = 1'b0;

        // peak on bank 2 at the third sample
        send(8'h10, cv(2, 3), 0);
        send(8'h11, cv(2, 4), 0);
        send(8'h12, cv(2, 5), 0);
        send(8'h13, cv(2, 4), 0);
        send(8'h14, cv(2, 2), 0);
        chk("t1_pre", a_pre, 1);
        chk("t1_bank", a_bank, 2);
        idle();
        chk("t1_pre_pulse", a_pre, 0);
        chk("t1_vld", a_out_vld, 1);
        chk("t1_first", a_out_dat, 8'h12);
        idle();
        chk("t1_second", a_out_dat, 8'h13);
        send(8'h00, 16'h0, 1);
        chk("t1_fe", a_fe, 1);
        chk("t1_vld_off", a_out_vld, 0);
        chk("t1_bank_clr", a_bank, 0);
        idle();
        chk("t1_fe_pulse", a_fe, 0);

        // tie between banks 1 and 3
        send(8'h20, cv(1, 3), 0);
        send(8'h21, cv(1, 5) | cv(3, 5), 0);
        send(8'h22, 16'h0, 0);
        chk("t2_pre", a_pre, 1);
        chk("t2_bank", a_bank, 1);
        idle();
        chk("t2_first", a_out_dat, 8'h21);
        send(8'h00, 16'h0, 1);
        idle();

        // FIND timeout after 8 valid samples
        for (int i = 0; i < 8; i++) begin
            send(8'(8'h30 + i), cv(0, 4), 0);
            if (i == 6) chk("t3_no_to", a_to, 0);
        end
        chk("t3_to", a_to, 1);
        chk("t3_vld", a_out_vld, 0);
        chk("t3_pre", a_pre, 0);
        idle();
        chk("t3_to_pulse", a_to, 0);
        send(8'h40, cv(0, 3), 0);
        send(8'h41, 16'h0, 0);
        chk("t3_reenter", a_pre, 1);
        send(8'h00, 16'h0, 1);
        idle();

        // frame limit of 5, latched at entry
        max_frame = 16'd5;
        send(8'h50, cv(0, 3), 0);
        max_frame = 16'd0;
        send(8'h51, 16'h0, 0);
        beats = 0;
        fe = 0;
        for (int i = 0; i < 10; i++) begin
            in_dat = 8'(8'h52 + i);
            corr   = '0;
            in_vld = 1'b1;
            tick();
            if (a_out_vld) begin
                chk("t4_dat", a_out_dat, 8'h50 + beats);
                beats++;
            end
            if (a_fe) begin
                chk("t4_fe_after_5", beats, 5);
                fe++;
            end
        end
        in_vld = 1'b0;
        chk("t4_beats", beats, 5);
        chk("t4_fe_count", fe, 1);

        // backpressure then all_zeros with output pending
        send(8'h60, cv(0, 3), 0);
        out_rdy = 1'b0;
        send(8'h61, 16'h0, 0);
        idle();
        chk("t5_vld", a_out_vld, 1);
        chk("t5_dat", a_out_dat, 8'h60);
        for (int i = 0; i < 10; i++) begin
            in_dat = 8'(8'h62 + i);
            corr   = '0;
            in_vld = 1'b1;
            tick();
            chk("t5_hold", {a_out_vld, a_out_dat}, {1'b1, 8'h60});
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        for (int k = 1; k < 6; k++) begin
            tick();
            chk("t5_seq", {a_out_vld, a_out_dat}, {1'b1, 8'(8'h60 + k)});
        end
        out_rdy = 1'b0;
        send(8'h00, 16'h0, 1);
        chk("t5_fe", a_fe, 1);
        chk("t5_vld_off", a_out_vld, 0);
        out_rdy = 1'b1;
        idle();

        // 8-deep buffer: 12 samples in FIND overflow 4 times, then reset mid-DATA
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ov = 0;
        for (int i = 0; i < 12; i++) begin
            send(8'(8'h80 + i), cv(3, 4), 0);
            ov += int'(b_ovf);
        end
        chk("t6_ovf", ov, 4);
        send(8'h8c, 16'h0, 0);
        chk("t6_bank", b_bank, 3);
        idle();
        chk("t6_vld", b_out_vld, 1);
        chk("t6_first", b_out_dat, 8'h80);
        rst = 1'b1;
        tick();
        chk("t6_rst_vld", b_out_vld, 0);
        chk("t6_rst_dat", b_out_dat, 0);
        chk("t6_rst_bank", b_bank, 0);
        chk("t6_rst_flags", {b_pre, b_to, b_fe, b_ovf}, 0);
        rst = 1'b0;
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
